// File: rtl/glay_req_pkg.sv
// Shared state encoding, default geometry and line-count helper for the
// GLAY setup request engine.
package glay_req_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int LINE_BYTES_DEF      = 64;
  localparam int MAX_OUTSTANDING_DEF = 16;

  // ceil((offset + nbytes) / 2**lb_log2); 34-bit sum so a 4 GiB job cannot wrap
  function automatic logic [32:0] line_count(input logic [31:0] offset,
                                             input logic [31:0] nbytes,
                                             input int          lb_log2);
    logic [33:0] sum;
    sum = {2'b00, offset} + {2'b00, nbytes} + ((34'd1 << lb_log2) - 34'd1);
    return 33'(sum >> lb_log2);
  endfunction

endpackage

// File: rtl/glay_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head word is visible on o_data
// whenever o_empty is low.
module glay_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: o_empty guards every read of stale contents.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
  end

endmodule

// File: rtl/glay_setup_req_engine.sv
// Expands a (base_addr, num_bytes) job into line-aligned cache requests,
// throttled by a cap on requests still waiting for a response.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for start; job parameters latched on start
// ST_GEN   | pushing one line address per cycle into the FIFO
// ST_DRAIN | all lines queued; waiting for FIFO empty and no outstanding
// ST_DONE  | completion; done pulses on the following cycle
module glay_setup_req_engine
  import glay_req_pkg::*;
#(
  parameter int ADDR_W          = 64,
  parameter int LINE_BYTES      = LINE_BYTES_DEF,
  parameter int FIFO_DEPTH      = 32,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                                 ap_clk,
  input  logic                                 ap_rst_n,
  input  logic                                 start,
  input  logic [ADDR_W-1:0]                    base_addr,
  input  logic [31:0]                          num_bytes,
  output logic                                 req_valid,
  input  logic                                 req_ready,
  output logic [ADDR_W-1:0]                    req_addr,
  input  logic                                 resp_valid,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);
  localparam int                OFF_W    = $clog2(LINE_BYTES);
  localparam int                CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);
  localparam logic [ADDR_W-1:0] LINE_INC = ADDR_W'(LINE_BYTES);
  localparam logic [CNT_W-1:0]  CNT_CAP  = CNT_W'(MAX_OUTSTANDING);

  state_e             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [32:0]        r_lines_left;
  logic [CNT_W-1:0]   r_out;
  logic               r_done;

  logic [ADDR_W-1:0]  w_aligned;
  logic [31:0]        w_offset;
  logic [32:0]        w_lines;
  logic               w_push;
  logic               w_pop;
  logic               w_dec;
  logic               w_full;
  logic               w_empty;
  logic               w_below_cap;
  logic [ADDR_W-1:0]  w_head;

  assign w_aligned   = base_addr & ~OFF_MASK;
  assign w_offset    = 32'(base_addr & OFF_MASK);
  assign w_lines     = line_count(w_offset, num_bytes, OFF_W);
  assign w_push      = (r_state == ST_GEN) && !w_full && (r_lines_left != '0);
  assign w_below_cap = (r_out < CNT_CAP);
  assign w_pop       = req_valid && req_ready;
  assign w_dec       = resp_valid && (r_out != '0);

  assign req_valid   = !w_empty && w_below_cap;
  // Gated so the bus reads zero whenever no request is offered, including reset.
  assign req_addr    = req_valid ? w_head : '0;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign outstanding = r_out;

  glay_sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .i_clk   (ap_clk),
    .i_rst_n (ap_rst_n),
    .i_push  (w_push),
    .i_data  (r_addr),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_lines_left <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr       <= w_aligned;
            r_lines_left <= w_lines;
            r_state      <= (num_bytes == 32'd0) ? ST_DONE : ST_GEN;
          end
        end
        ST_GEN: begin
          if (w_push) begin
            r_addr       <= r_addr + LINE_INC;
            r_lines_left <= r_lines_left - 33'd1;
            if (r_lines_left == 33'd1) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_empty && (r_out == '0)) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Responses with nothing outstanding (e.g. from a job killed by reset) are dropped.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_out <= '0;
    end else begin
      case ({w_pop, w_dec})
        2'b10:   r_out <= r_out + 1'b1;
        2'b01:   r_out <= r_out - 1'b1;
        default: r_out <= r_out;
      endcase
    end
  end

endmodule

// File: tb/tb_glay_setup_req_engine.sv
// Self-checking bench: directed vector table, backpressure and reset corner
// sequences, then randomized jobs against an address-list reference model.
module tb_glay_setup_req_engine;

  localparam int MAXO = 16;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        start;
  logic [63:0] base_addr;
  logic [31:0] num_bytes;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic        busy;
  logic        done;
  logic [4:0]  outstanding;

  glay_setup_req_engine dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .num_bytes   (num_bytes),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .resp_valid  (resp_valid),
    .busy        (busy),
    .done        (done),
    .outstanding (outstanding)
  );

  always #5 ap_clk = ~ap_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ready_pct = 100;
  int resp_delay = 3;
  int block_until = 0;
  int hold_until = 0;
  int stray = 0;
  int m_out = 0;
  int m_max = 0;
  int done_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_addr = '0;
  logic        hs;
  logic [63:0] obs[$];
  logic [63:0] exp_q[$];
  int          pend[$];

  typedef struct {
    logic [63:0] base;
    logic [31:0] nbytes;
    int          lines;
    logic [63:0] first;
    logic [63:0] last;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge ap_clk) cyc <= cyc + 1;

  // Stimulus for the cache side: ready pattern and delayed responses.
  initial begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    forever begin
      @(posedge ap_clk);
      #1;
      req_ready  = (cyc >= block_until) && (int'($urandom_range(99)) < ready_pct);
      resp_valid = 1'b0;
      if (stray > 0) begin
        resp_valid = 1'b1;
        stray--;
      end else if (pend.size() > 0 && pend[0] <= cyc && cyc >= hold_until) begin
        resp_valid = 1'b1;
        void'(pend.pop_front());
      end
    end
  end

  // Monitor: outstanding count rule, cap, hold-while-stalled, reset values.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      m_out      = 0;
      prev_stall = 1'b0;
      chk("rst_valid_busy_done", 64'({req_valid, busy, done}), 64'd0);
      chk("rst_req_addr", req_addr, 64'd0);
      chk("rst_outstanding", 64'(outstanding), 64'd0);
    end else begin
      chk("outstanding", 64'(outstanding), 64'(m_out));
      chk("cap_respected", 64'(req_valid && (m_out >= MAXO)), 64'd0);
      if (prev_stall) begin
        chk("stall_hold_valid", 64'(req_valid), 64'd1);
        chk("stall_hold_addr", req_addr, prev_addr);
      end
      if (done) done_cnt++;
      if (int'(outstanding) > m_max) m_max = int'(outstanding);
      hs = req_valid && req_ready;
      if (hs) begin
        obs.push_back(req_addr);
        pend.push_back(cyc + resp_delay);
      end
      m_out = m_out + (hs ? 1 : 0) - ((resp_valid && m_out != 0) ? 1 : 0);
      prev_stall = req_valid && !req_ready;
      prev_addr  = req_addr;
    end
  end

  // Reference: every line touched by [b, b+n), starting from the aligned base.
  task automatic build_model(input logic [63:0] b, input logic [31:0] n);
    logic [63:0] off;
    logic [63:0] lines;
    exp_q.delete();
    off   = b % 64;
    lines = (n == 0) ? 64'd0 : (off + 64'(n) + 64'd63) / 64'd64;
    for (logic [63:0] i = 0; i < lines; i++) exp_q.push_back((b - off) + i * 64);
  endtask

  task automatic run_job(input logic [63:0] b, input logic [31:0] n, input int rpct,
                         input int rdly, input int blk, input int hold);
    int first_v;
    int done_at;
    build_model(b, n);
    @(posedge ap_clk);
    #1;
    obs.delete();
    done_cnt    = 0;
    m_max       = 0;
    ready_pct   = rpct;
    resp_delay  = rdly;
    block_until = cyc + blk;
    hold_until  = cyc + hold;
    base_addr   = b;
    num_bytes   = n;
    start       = 1'b1;
    first_v     = -1;
    done_at     = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge ap_clk);
      if (k == 1) begin
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
      end
      if (req_valid && first_v < 0) first_v = k;
      if (done) begin
        done_at = k;
        break;
      end
    end
    repeat (4) @(negedge ap_clk);
    start = 1'b0;
    chk("job_finished", 64'(done_at >= 0), 64'd1);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("busy_after_done", 64'(busy), 64'd0);
    if (exp_q.size() == 0) begin
      chk("zero_len_done_cycle", 64'(done_at), 64'd2);
      chk("zero_len_no_req", 64'(first_v < 0), 64'd1);
    end else begin
      chk("first_req_latency", 64'(first_v), 64'd2);
    end
    chk("req_count", 64'(obs.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk("req_addr_seq", (i < obs.size()) ? obs[i] : ~exp_q[i], exp_q[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int   waited;
    logic [63:0] rb;
    logic [31:0] rn;

    tbl[0] = '{64'h1000, 32'd256, 4, 64'h1000, 64'h10C0};
    tbl[1] = '{64'h1030, 32'h20, 2, 64'h1000, 64'h1040};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFC0, 32'd128, 2, 64'hFFFF_FFFF_FFFF_FFC0, 64'h0};
    tbl[3] = '{64'h203F, 32'd1, 1, 64'h2000, 64'h2000};
    tbl[4] = '{64'h203F, 32'd2, 2, 64'h2000, 64'h2040};
    tbl[5] = '{64'h4010, 32'd0, 0, 64'h0, 64'h0};

    ap_rst_n  = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_bytes = '0;
    repeat (3) @(posedge ap_clk);
    #3 ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("post_reset_valid", 64'(req_valid), 64'd0);
    chk("post_reset_done", 64'(done), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_job(tbl[i].base, tbl[i].nbytes, 100, 3, 0, 0);
      chk("tbl_lines", 64'(obs.size()), 64'(tbl[i].lines));
      if (tbl[i].lines > 0 && obs.size() > 0) begin
        chk("tbl_first_addr", obs[0], tbl[i].first);
        chk("tbl_last_addr", obs[$], tbl[i].last);
      end
    end

    // Backpressure: 64 lines, ready held low 40 cycles, responses held until cycle 60.
    run_job(64'h8000, 32'd4096, 100, 3, 40, 60);
    chk("bp_max_outstanding", 64'(m_max), 64'd16);
    chk("bp_req_count", 64'(obs.size()), 64'd64);

    // Reset mid-job with 5 requests outstanding.
    @(posedge ap_clk);
    #1;
    ready_pct = 100; resp_delay = 1000; block_until = 0; hold_until = 0;
    done_cnt = 0;
    base_addr = 64'h3000; num_bytes = 32'd4096; start = 1'b1;
    @(posedge ap_clk);
    #1 start = 1'b0;
    waited = 0;
    while (outstanding != 5'd5 && waited < 100) begin
      @(negedge ap_clk);
      waited++;
    end
    chk("reached_5_outstanding", 64'(outstanding), 64'd5);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("rst_now_valid", 64'(req_valid), 64'd0);
    chk("rst_now_busy", 64'(busy), 64'd0);
    chk("rst_now_outstanding", 64'(outstanding), 64'd0);
    chk("rst_now_addr", req_addr, 64'd0);
    pend.delete();
    repeat (3) @(posedge ap_clk);
    #3 ap_rst_n = 1'b1;
    stray = 3;
    repeat (6) @(negedge ap_clk);
    chk("stray_resp_ignored", 64'(outstanding), 64'd0);
    chk("no_done_for_aborted", 64'(done_cnt), 64'd0);
    chk("idle_after_abort", 64'(busy), 64'd0);
    run_job(64'h3000, 32'd256, 100, 3, 0, 0);

    // Randomized jobs against the reference model.
    for (int j = 0; j < 14; j++) begin
      rb = {$urandom, $urandom};
      if ($urandom_range(3) == 0) rb = 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(255));
      rn = $urandom_range(700);
      if ($urandom_range(7) == 0) rn = 32'd0;
      run_job(rb, rn, int'($urandom_range(100, 20)), int'($urandom_range(12, 1)), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
